controlador_de_barrido_7seg: RTL and testbench
==============================================

Name: controlador_de_barrido_7seg

Overview:
Scan and message scheduler for the 4-digit 7-segment display. It time-multiplexes digit anodes with a programmable refresh rate and anti-ghosting blank interval. It also arbitrates which active alarm (HUMO, TEMP, SOBRECARGA) owns the display, rotating round-robin at frame boundaries. Its outputs drive the existing segment decoder: digit index as conteo, alarm code into the estado-to-segments path.

Parameters:
DIV_REFRESCO, 50000, CLK cycles per digit slot (>=2)
BLANK_CICLOS, 500, cycles at start of each slot with all anodes off (0 allowed; must be < DIV_REFRESCO)
TRAMAS_POR_ALARMA, 250, full 4-digit frames an alarm is shown before rotating (>=1)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
HABILITAR  input  1  display enable, synchronous level
HUMO  input  1  smoke alarm level, already synchronized to CLK
TEMP  input  1  temperature alarm level, already synchronized to CLK
SOBRECARGA  input  1  overload alarm level, already synchronized to CLK
DISPLAY  output  4  anode selects, active-low
DIGITO_SEL  output  2  index of the current digit slot
ALARMA_ACT  output  2  alarm shown: 0 none, 1 HUMO, 2 TEMP, 3 SOBRECARGA
BLANK  output  1  high while anodes are forced off
TRAMA_FIN  output  1  one-cycle pulse when a frame completes

Behaviour:
- One clock, CLK. RST is asynchronous and active-low.
- All outputs are registered.
- Reset values: DIGITO_SEL=0, DISPLAY=4'b1111, BLANK=1, TRAMA_FIN=0, ALARMA_ACT=0.
- Reset also forces FSM=REPOSO, prescaler=0, frame counter=0, round-robin pointer=0 (the next search starts at HUMO).

Prescaler:
- cnt_div counts 0..DIV_REFRESCO-1 and wraps.
- The slot ends when cnt_div==DIV_REFRESCO-1.

Blanking:
- While cnt_div<BLANK_CICLOS: DISPLAY=4'b1111 and BLANK=1.
- Otherwise: DISPLAY=~(4'b0001<<DIGITO_SEL) and BLANK=0.

Digit sequencing:
- At slot end, DIGITO_SEL increments mod 4.
- On the 3->0 wrap, TRAMA_FIN=1 for exactly the cycle in which DIGITO_SEL becomes 0.
- DIGITO_SEL changes only during the blank phase of the new slot; with BLANK_CICLOS=0 it changes with the anode pattern in the same cycle.

HABILITAR=0:
- Prescaler, DIGITO_SEL and the frame counter are held at 0.
- DISPLAY=1111, BLANK=1, TRAMA_FIN=0.
- ALARMA_ACT and the FSM are held.
- On re-enable, the block starts at digit 0, cnt_div=0, in the blank phase.

Arbiter FSM (states REPOSO, MOSTRAR):
- Decisions are taken only on a TRAMA_FIN cycle. ALARMA_ACT never changes mid-frame.
- Active mask m = {SOBRECARGA,TEMP,HUMO}.
- REPOSO: ALARMA_ACT=0. On TRAMA_FIN with m!=0, select the first set bit searching round-robin from the pointer, go to MOSTRAR, clear the frame counter.
- MOSTRAR, on each TRAMA_FIN:
  - Current alarm still active, frame counter < TRAMAS_POR_ALARMA-1: increment the frame counter.
  - Current alarm still active, frame counter == TRAMAS_POR_ALARMA-1: set pointer = current+1 (mod 3), select the next active alarm round-robin (it may be the same one if it is the only one active), clear the counter.
  - Current alarm deasserted: switch at this frame boundary without waiting out the dwell. Select the next active alarm round-robin, or go to REPOSO with ALARMA_ACT=0 if m==0.
- Alarms that pulse and clear entirely between frame boundaries are not shown (level semantics, no latching).

Arithmetic:
- Counter widths are $clog2 of their terminal value, minimum 1.
- No counter may overflow past its terminal value.

Reset mid-operation:
- All state returns to the reset values immediately (asynchronously).
- After RST deasserts, the first TRAMA_FIN occurs after exactly 4*DIV_REFRESCO cycles.

Decomposition:
- Shared package holds:
  - alarm code constants ALARMA_NINGUNA=2'd0, ALARMA_HUMO=2'd1, ALARMA_TEMP=2'd2, ALARMA_SOBRECARGA=2'd3
  - FSM state encoding REPOSO/MOSTRAR
- One natural sub-module, divisor_de_refresco: prescaler producing the slot-end tick and the blank-phase flag, parameterized by DIV_REFRESCO and BLANK_CICLOS, with synchronous clear from HABILITAR.
- Digit sequencing and the arbiter stay in the top of the block.

Test Plan:
All scenarios use DIV_REFRESCO=8, BLANK_CICLOS=2, TRAMAS_POR_ALARMA=3.
- Reset/scan: hold RST low, then release with HABILITAR=1 and no alarms. DISPLAY shows 1111 for 2 cycles, then 1110 for 6 cycles, then the same pattern for 1101, 1011, 0111. TRAMA_FIN pulses at cycle 32. ALARMA_ACT stays 0.
- Single alarm: assert TEMP mid-frame 0. ALARMA_ACT=2 from the first TRAMA_FIN and is unchanged mid-frame. It stays 2 across every later TRAMA_FIN while TEMP holds.
- Rotation: assert HUMO and SOBRECARGA together. Sequence is 1 for 3 frames, 3 for 3 frames, 1 again. Each switch coincides with a TRAMA_FIN cycle.
- Early drop: with HUMO shown at frame 1 of 3, deassert HUMO while TEMP is active. ALARMA_ACT becomes 2 at the next TRAMA_FIN. If all alarms clear, it becomes 0 and the FSM returns to REPOSO.
- Disable: drop HABILITAR mid-slot on digit 2. DISPLAY=1111 and BLANK=1 the next cycle, ALARMA_ACT held. On re-enable, DIGITO_SEL=0 with 2 blank cycles first.
- Async reset mid-frame: pulse RST low for less than one clock period while ALARMA_ACT=3. Outputs return to reset values without waiting for a CLK edge. The next TRAMA_FIN arrives 32 cycles after release.

Source files
------------

// File: rtl/controlador_de_barrido_7seg_pkg.sv
// Shared alarm codes, arbiter state encoding and round-robin helpers
// for the 7-segment scan controller.
package controlador_de_barrido_7seg_pkg;

  localparam logic [1:0] ALARMA_NINGUNA    = 2'd0;
  localparam logic [1:0] ALARMA_HUMO       = 2'd1;
  localparam logic [1:0] ALARMA_TEMP       = 2'd2;
  localparam logic [1:0] ALARMA_SOBRECARGA = 2'd3;

  localparam int unsigned N_ALARMAS       = 3;
  localparam logic [3:0]  ANODOS_APAGADOS = 4'b1111;

  typedef enum logic {
    REPOSO  = 1'b0,
    MOSTRAR = 1'b1
  } estado_t;

  // Mask bit index (0 HUMO, 1 TEMP, 2 SOBRECARGA) advanced modulo 3.
  function automatic logic [1:0] siguiente_indice(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

  // First set mask bit found walking round-robin from inicio.
  function automatic logic [1:0] buscar_rr(input logic [2:0] mascara,
                                           input logic [1:0] inicio);
    logic [1:0] idx;
    logic [1:0] res;
    logic       hallado;
    idx     = inicio;
    res     = inicio;
    hallado = 1'b0;
    for (int i = 0; i < int'(N_ALARMAS); i++) begin
      if (!hallado && mascara[idx]) begin
        res     = idx;
        hallado = 1'b1;
      end
      idx = siguiente_indice(idx);
    end
    return res;
  endfunction

  // Mask bit index to displayed alarm code.
  function automatic logic [1:0] codigo_de_indice(input logic [1:0] idx);
    return 2'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/controlador_de_barrido_7seg_divisor_de_refresco.sv
// Digit-slot prescaler: slot-end tick plus the anti-ghosting blank flag,
// cleared synchronously while the display is disabled.
module divisor_de_refresco #(
  parameter int unsigned DIV_REFRESCO = 50000,
  parameter int unsigned BLANK_CICLOS = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilitar,
  output logic fin_ranura_c,
  output logic en_blanco_sig_c,
  output logic en_blanco
);

  localparam int unsigned ANCHO_DIV =
    ($clog2(DIV_REFRESCO) > 0) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [ANCHO_DIV-1:0] ULTIMO_DIV = ANCHO_DIV'(DIV_REFRESCO - 1);

  logic [ANCHO_DIV-1:0] cnt_div;
  logic [ANCHO_DIV-1:0] cnt_sig_c;

  // Next prescaler value; wraps at the slot end so it never passes ULTIMO_DIV.
  always_comb begin
    cnt_sig_c       = cnt_div;
    fin_ranura_c    = 1'b0;
    en_blanco_sig_c = 1'b1;
    if (habilitar) begin
      fin_ranura_c    = (cnt_div == ULTIMO_DIV);
      cnt_sig_c       = fin_ranura_c ? '0 : ANCHO_DIV'(cnt_div + 1'b1);
      en_blanco_sig_c = (32'(cnt_sig_c) < BLANK_CICLOS);
    end else begin
      cnt_sig_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_div   <= '0;
      en_blanco <= 1'b1;
    end else begin
      cnt_div   <= cnt_sig_c;
      en_blanco <= en_blanco_sig_c;
    end
  end

endmodule

// File: rtl/controlador_de_barrido_7seg.sv
// 4-digit 7-segment scan controller with blanking and a round-robin
// arbiter choosing which active alarm owns the display each frame.
module controlador_de_barrido_7seg #(
  parameter int unsigned DIV_REFRESCO      = 50000,
  parameter int unsigned BLANK_CICLOS      = 500,
  parameter int unsigned TRAMAS_POR_ALARMA = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       HABILITAR,
  input  logic       HUMO,
  input  logic       TEMP,
  input  logic       SOBRECARGA,
  output logic [3:0] DISPLAY,
  output logic [1:0] DIGITO_SEL,
  output logic [1:0] ALARMA_ACT,
  output logic       BLANK,
  output logic       TRAMA_FIN
);

  import controlador_de_barrido_7seg_pkg::*;

  localparam int unsigned ANCHO_TRAMAS =
    ($clog2(TRAMAS_POR_ALARMA) > 0) ? $clog2(TRAMAS_POR_ALARMA) : 1;
  localparam logic [ANCHO_TRAMAS-1:0] ULTIMA_TRAMA =
    ANCHO_TRAMAS'(TRAMAS_POR_ALARMA - 1);

  logic                    fin_ranura_c;
  logic                    en_blanco_sig_c;
  logic [1:0]              digito_sig_c;
  logic                    fin_trama_c;
  logic [2:0]              mascara_c;
  logic [1:0]              indice_act_c;
  logic                    actual_activa_c;
  logic [1:0]              indice_sig_c;
  estado_t                 estado;
  logic [1:0]              puntero;
  logic [ANCHO_TRAMAS-1:0] cnt_tramas;

  divisor_de_refresco #(
    .DIV_REFRESCO (DIV_REFRESCO),
    .BLANK_CICLOS (BLANK_CICLOS)
  ) u_divisor (
    .clk             (CLK),
    .rst_n           (RST),
    .habilitar       (HABILITAR),
    .fin_ranura_c    (fin_ranura_c),
    .en_blanco_sig_c (en_blanco_sig_c),
    .en_blanco       (BLANK)
  );

  // Digit advance and frame-boundary detection.
  always_comb begin
    digito_sig_c = DIGITO_SEL;
    if (!HABILITAR)
      digito_sig_c = 2'd0;
    else if (fin_ranura_c)
      digito_sig_c = 2'(DIGITO_SEL + 2'd1);
    fin_trama_c = fin_ranura_c && (DIGITO_SEL == 2'd3);
  end

  // Anodes follow the next-cycle digit so they switch together with DIGITO_SEL.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DIGITO_SEL <= 2'd0;
      DISPLAY    <= ANODOS_APAGADOS;
      TRAMA_FIN  <= 1'b0;
    end else begin
      DIGITO_SEL <= digito_sig_c;
      DISPLAY    <= en_blanco_sig_c ? ANODOS_APAGADOS
                                    : ~(4'b0001 << digito_sig_c);
      TRAMA_FIN  <= fin_trama_c;
    end
  end

  // Mask index of the alarm on display and whether it is still asserted.
  always_comb begin
    mascara_c       = {SOBRECARGA, TEMP, HUMO};
    indice_act_c    = 2'd0;
    actual_activa_c = 1'b0;
    case (ALARMA_ACT)
      ALARMA_HUMO:       begin indice_act_c = 2'd0; actual_activa_c = HUMO;       end
      ALARMA_TEMP:       begin indice_act_c = 2'd1; actual_activa_c = TEMP;       end
      ALARMA_SOBRECARGA: begin indice_act_c = 2'd2; actual_activa_c = SOBRECARGA; end
      default:           begin indice_act_c = 2'd0; actual_activa_c = 1'b0;       end
    endcase
    indice_sig_c = siguiente_indice(indice_act_c);
  end

  // Arbiter: all decisions land on the frame boundary, so ALARMA_ACT is frame-stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      estado     <= REPOSO;
      ALARMA_ACT <= ALARMA_NINGUNA;
      puntero    <= 2'd0;
      cnt_tramas <= '0;
    end else if (!HABILITAR) begin
      cnt_tramas <= '0;
    end else if (fin_trama_c) begin
      case (estado)
        REPOSO: begin
          if (mascara_c != 3'b000) begin
            ALARMA_ACT <= codigo_de_indice(buscar_rr(mascara_c, puntero));
            estado     <= MOSTRAR;
            cnt_tramas <= '0;
          end
        end
        MOSTRAR: begin
          if (actual_activa_c && (cnt_tramas < ULTIMA_TRAMA)) begin
            cnt_tramas <= ANCHO_TRAMAS'(cnt_tramas + 1'b1);
          end else if (mascara_c == 3'b000) begin
            estado     <= REPOSO;
            ALARMA_ACT <= ALARMA_NINGUNA;
            cnt_tramas <= '0;
          end else begin
            // Dwell expired or the shown alarm dropped: hand over round-robin.
            puntero    <= indice_sig_c;
            ALARMA_ACT <= codigo_de_indice(buscar_rr(mascara_c, indice_sig_c));
            cnt_tramas <= '0;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_de_barrido_7seg.sv
// Directed bench for the 7-segment scan controller (DIV=8, BLANK=2, TRAMAS=3).
module tb_controlador_de_barrido_7seg;

  logic       CLK;
  logic       RST;
  logic       HABILITAR;
  logic       HUMO;
  logic       TEMP;
  logic       SOBRECARGA;
  logic [3:0] DISPLAY;
  logic [1:0] DIGITO_SEL;
  logic [1:0] ALARMA_ACT;
  logic       BLANK;
  logic       TRAMA_FIN;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  controlador_de_barrido_7seg #(
    .DIV_REFRESCO      (8),
    .BLANK_CICLOS      (2),
    .TRAMAS_POR_ALARMA (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .HABILITAR  (HABILITAR),
    .HUMO       (HUMO),
    .TEMP       (TEMP),
    .SOBRECARGA (SOBRECARGA),
    .DISPLAY    (DISPLAY),
    .DIGITO_SEL (DIGITO_SEL),
    .ALARMA_ACT (ALARMA_ACT),
    .BLANK      (BLANK),
    .TRAMA_FIN  (TRAMA_FIN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic avanzar(input int n);
    repeat (n) begin
      @(negedge CLK);
      t++;
    end
  endtask

  task automatic ir_a(input int c);
    if (c > t) avanzar(c - t);
  endtask

  // Reset with display enabled and no alarms; cycle 0 is the first cycle after release.
  task automatic aplicar_reset();
    @(negedge CLK);
    RST = 1'b0; HABILITAR = 1'b1; HUMO = 1'b0; TEMP = 1'b0; SOBRECARGA = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    t = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_disp;
    logic [1:0] exp_dig;
    logic       exp_blank;
    logic       exp_fin;
    RST = 1'b0; HABILITAR = 1'b1; HUMO = 1'b0; TEMP = 1'b0; SOBRECARGA = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (DISPLAY !== 4'b1111 || BLANK !== 1'b1 || DIGITO_SEL !== 2'd0 ||
        TRAMA_FIN !== 1'b0 || ALARMA_ACT !== 2'd0) begin
      bad++;
      $display("FAIL reset_values: got DISPLAY=%b BLANK=%b DIGITO_SEL=%0d TRAMA_FIN=%b ALARMA_ACT=%0d, want 1111 1 0 0 0",
               DISPLAY, BLANK, DIGITO_SEL, TRAMA_FIN, ALARMA_ACT);
    end
    RST = 1'b1;
    t = 0;
    for (int c = 0; c <= 32; c++) begin
      ir_a(c);
      exp_dig   = 2'((c / 8) % 4);
      exp_blank = ((c % 8) < 2);
      exp_disp  = exp_blank ? 4'b1111 : ~(4'b0001 << exp_dig);
      exp_fin   = (c == 32);
      total++;
      if (DISPLAY !== exp_disp || DIGITO_SEL !== exp_dig || BLANK !== exp_blank ||
          TRAMA_FIN !== exp_fin || ALARMA_ACT !== 2'd0) begin
        bad++;
        $display("FAIL scan c=%0d: got DISPLAY=%b DIGITO_SEL=%0d BLANK=%b TRAMA_FIN=%b ALARMA_ACT=%0d, want %b %0d %b %b 0",
                 c, DISPLAY, DIGITO_SEL, BLANK, TRAMA_FIN, ALARMA_ACT, exp_disp, exp_dig, exp_blank, exp_fin);
      end
    end
  endtask

  task automatic test_single_alarm();
    aplicar_reset();
    ir_a(5);
    TEMP = 1'b1;
    ir_a(31);
    total++;
    if (ALARMA_ACT !== 2'd0 || TRAMA_FIN !== 1'b0) begin
      bad++;
      $display("FAIL single_before_frame: got ALARMA_ACT=%0d TRAMA_FIN=%b, want 0 0", ALARMA_ACT, TRAMA_FIN);
    end
    for (int k = 1; k <= 5; k++) begin
      ir_a(32 * k);
      total++;
      if (ALARMA_ACT !== 2'd2 || TRAMA_FIN !== 1'b1) begin
        bad++;
        $display("FAIL single_boundary k=%0d: got ALARMA_ACT=%0d TRAMA_FIN=%b, want 2 1", k, ALARMA_ACT, TRAMA_FIN);
      end
      ir_a(32 * k + 16);
      total++;
      if (ALARMA_ACT !== 2'd2 || TRAMA_FIN !== 1'b0) begin
        bad++;
        $display("FAIL single_midframe k=%0d: got ALARMA_ACT=%0d TRAMA_FIN=%b, want 2 0", k, ALARMA_ACT, TRAMA_FIN);
      end
    end
    TEMP = 1'b0;
  endtask

  task automatic test_rotation();
    int esperado [0:7];
    esperado = '{0, 1, 1, 1, 3, 3, 3, 1};
    aplicar_reset();
    ir_a(1);
    HUMO = 1'b1;
    SOBRECARGA = 1'b1;
    for (int f = 1; f <= 7; f++) begin
      ir_a(32 * f - 1);
      total++;
      if (ALARMA_ACT !== 2'(esperado[f-1]) || TRAMA_FIN !== 1'b0) begin
        bad++;
        $display("FAIL rotation_pre f=%0d: got ALARMA_ACT=%0d TRAMA_FIN=%b, want %0d 0", f, ALARMA_ACT, TRAMA_FIN, esperado[f-1]);
      end
      ir_a(32 * f);
      total++;
      if (ALARMA_ACT !== 2'(esperado[f]) || TRAMA_FIN !== 1'b1) begin
        bad++;
        $display("FAIL rotation_boundary f=%0d: got ALARMA_ACT=%0d TRAMA_FIN=%b, want %0d 1", f, ALARMA_ACT, TRAMA_FIN, esperado[f]);
      end
    end
    HUMO = 1'b0;
    SOBRECARGA = 1'b0;
  endtask

  task automatic test_early_drop();
    int ciclos [0:7];
    int valores [0:7];
    ciclos  = '{32, 64, 95, 96, 127, 128, 159, 160};
    valores = '{1,  1,  1,  2,  2,   0,   0,   3};
    aplicar_reset();
    ir_a(1);
    HUMO = 1'b1;
    TEMP = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ciclos[i] > 70 && t < 70) begin ir_a(70); HUMO = 1'b0; end
      if (ciclos[i] > 100 && t < 100) begin ir_a(100); TEMP = 1'b0; end
      if (ciclos[i] > 140 && t < 140) begin ir_a(140); SOBRECARGA = 1'b1; end
      ir_a(ciclos[i]);
      total++;
      if (ALARMA_ACT !== 2'(valores[i]) || TRAMA_FIN !== ((ciclos[i] % 32) == 0)) begin
        bad++;
        $display("FAIL early_drop c=%0d: got ALARMA_ACT=%0d TRAMA_FIN=%b, want %0d %b",
                 ciclos[i], ALARMA_ACT, TRAMA_FIN, valores[i], ((ciclos[i] % 32) == 0));
      end
    end
    SOBRECARGA = 1'b0;
  endtask

  task automatic test_disable();
    aplicar_reset();
    ir_a(1);
    TEMP = 1'b1;
    ir_a(52);
    total++;
    if (DISPLAY !== 4'b1011 || DIGITO_SEL !== 2'd2 || BLANK !== 1'b0 || ALARMA_ACT !== 2'd2) begin
      bad++;
      $display("FAIL disable_pre: got DISPLAY=%b DIGITO_SEL=%0d BLANK=%b ALARMA_ACT=%0d, want 1011 2 0 2",
               DISPLAY, DIGITO_SEL, BLANK, ALARMA_ACT);
    end
    HABILITAR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      avanzar(1);
      total++;
      if (DISPLAY !== 4'b1111 || BLANK !== 1'b1 || DIGITO_SEL !== 2'd0 ||
          TRAMA_FIN !== 1'b0 || ALARMA_ACT !== 2'd2) begin
        bad++;
        $display("FAIL disable_hold i=%0d: got DISPLAY=%b BLANK=%b DIGITO_SEL=%0d TRAMA_FIN=%b ALARMA_ACT=%0d, want 1111 1 0 0 2",
                 i, DISPLAY, BLANK, DIGITO_SEL, TRAMA_FIN, ALARMA_ACT);
      end
    end
    HABILITAR = 1'b1;
    t = 0;
    avanzar(1);
    total++;
    if (DISPLAY !== 4'b1111 || BLANK !== 1'b1 || DIGITO_SEL !== 2'd0) begin
      bad++;
      $display("FAIL reenable_blank: got DISPLAY=%b BLANK=%b DIGITO_SEL=%0d, want 1111 1 0", DISPLAY, BLANK, DIGITO_SEL);
    end
    avanzar(1);
    total++;
    if (DISPLAY !== 4'b1110 || BLANK !== 1'b0 || DIGITO_SEL !== 2'd0) begin
      bad++;
      $display("FAIL reenable_show: got DISPLAY=%b BLANK=%b DIGITO_SEL=%0d, want 1110 0 0", DISPLAY, BLANK, DIGITO_SEL);
    end
    ir_a(31);
    total++;
    if (TRAMA_FIN !== 1'b0) begin
      bad++;
      $display("FAIL reenable_pre_frame: got TRAMA_FIN=%b, want 0", TRAMA_FIN);
    end
    ir_a(32);
    total++;
    if (TRAMA_FIN !== 1'b1 || ALARMA_ACT !== 2'd2) begin
      bad++;
      $display("FAIL reenable_frame: got TRAMA_FIN=%b ALARMA_ACT=%0d, want 1 2", TRAMA_FIN, ALARMA_ACT);
    end
    TEMP = 1'b0;
  endtask

  task automatic test_async_reset();
    aplicar_reset();
    ir_a(1);
    SOBRECARGA = 1'b1;
    ir_a(44);
    total++;
    if (ALARMA_ACT !== 2'd3 || DISPLAY !== 4'b1101 || BLANK !== 1'b0) begin
      bad++;
      $display("FAIL async_pre: got ALARMA_ACT=%0d DISPLAY=%b BLANK=%b, want 3 1101 0", ALARMA_ACT, DISPLAY, BLANK);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if (DISPLAY !== 4'b1111 || BLANK !== 1'b1 || DIGITO_SEL !== 2'd0 ||
        TRAMA_FIN !== 1'b0 || ALARMA_ACT !== 2'd0) begin
      bad++;
      $display("FAIL async_values: got DISPLAY=%b BLANK=%b DIGITO_SEL=%0d TRAMA_FIN=%b ALARMA_ACT=%0d, want 1111 1 0 0 0",
               DISPLAY, BLANK, DIGITO_SEL, TRAMA_FIN, ALARMA_ACT);
    end
    #1 RST = 1'b1;
    t = 0;
    for (int n = 1; n <= 32; n++) begin
      avanzar(1);
      total++;
      if (TRAMA_FIN !== (n == 32)) begin
        bad++;
        $display("FAIL async_frame n=%0d: got TRAMA_FIN=%b, want %b", n, TRAMA_FIN, (n == 32));
      end
    end
    total++;
    if (ALARMA_ACT !== 2'd3) begin
      bad++;
      $display("FAIL async_alarm: got ALARMA_ACT=%0d, want 3", ALARMA_ACT);
    end
    SOBRECARGA = 1'b0;
  endtask

  initial begin
    RST = 1'b0; HABILITAR = 1'b0; HUMO = 1'b0; TEMP = 1'b0; SOBRECARGA = 1'b0;
    test_reset();
    test_single_alarm();
    test_rotation();
    test_early_drop();
    test_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
